wr_ctrl_lvl: RTL
================

Name: wr_ctrl_lvl

Overview:
Write-side control for the dual-clock asynchronous FIFO. It is the counterpart of the read control block, living entirely in the write clock domain. It keeps the binary and Gray write pointers and produces the memory write enable and address. From the synchronized Gray read pointer it also generates registered full, almost-full, fill level and a sticky overflow flag.

Parameters:
pADDR_WIDTH, 4, memory address width; FIFO depth = 2**pADDR_WIDTH; pointers are pADDR_WIDTH+1 bits.
pAFULL_THRESH, 12, wr_almost_full asserts when level >= this value; legal range 1..2**pADDR_WIDTH.

Ports:
wr_clk  input  1  write-domain clock; all logic on rising edge.
wr_rst_n  input  1  synchronous, active-low reset, sampled on wr_clk rising edge.
wr_push  input  1  write request for this cycle.
wr_ovf_clr  input  1  clears sticky overflow flag (feature-dependent).
rd_ptr  input  pADDR_WIDTH+1  Gray read pointer, already 2-FF synchronized into wr_clk domain.
wr_en  output  1  memory write strobe = wr_push && !wr_full (combinational).
wr_addr  output  pADDR_WIDTH  memory write address = low bits of binary write pointer.
wr_ptr  output  pADDR_WIDTH+1  registered Gray write pointer, sent to read domain synchronizer.
wr_full  output  1  registered full flag.
wr_almost_full  output  1  registered, level >= pAFULL_THRESH.
wr_level  output  pADDR_WIDTH+1  registered fill level, 0..2**pADDR_WIDTH, as seen by write side.
wr_overflow  output  1  sticky: push attempted while full.

Behaviour:
- Reset (wr_rst_n low at a wr_clk edge): wr_bin, wr_gray, wr_full, wr_almost_full, wr_level and wr_overflow all go to 0. Assertion between edges has no effect until the next edge. Resetting mid-operation discards the pointer; the read side must be reset together with it.
- Accept: wr_bin_nxt = wr_bin + (wr_push && !wr_full), with (pADDR_WIDTH+1)-bit wrap. wr_gray_nxt = wr_bin_nxt ^ (wr_bin_nxt >> 1). Both are registered every cycle.
- Memory write: the memory writes data at the current wr_addr in the cycle where wr_en=1. The address advances on the same edge.
- Full: full_val = (wr_gray_nxt == {~rd_ptr[MSB:MSB-1], rd_ptr[MSB-2:0]}), registered into wr_full. Full asserts on the edge that accepts the 2**pADDR_WIDTH-th outstanding word, so no extra cycle of exposure.
- Level: rd_bin_s = Gray-to-binary(rd_ptr), combinational XOR prefix from the MSB. lvl_nxt = wr_bin_nxt - rd_bin_s, modulo 2**(pADDR_WIDTH+1). wr_level <= lvl_nxt and wr_almost_full <= (lvl_nxt >= pAFULL_THRESH).
- Pessimism: rd_ptr lags the true read pointer by the synchronizer delay. Full and level may therefore overstate occupancy, never understate it. When rd_ptr advances, wr_full deasserts on the next wr_clk edge.
- Push while full: the push is dropped. wr_en=0, pointers unchanged, no memory write.
- wr_ptr changes at most one bit per cycle, including at the wrap 2**(pADDR_WIDTH+1)-1 -> 0.
- Simultaneous push and rd_ptr advance in the same cycle: both are folded into the *_nxt computations, and the flags reflect both on the next edge.

Optional Feature:
WR_OVF_FLAG_EN
- Defined: wr_overflow is set on any edge with wr_push && wr_full and stays set until an edge with wr_ovf_clr=1. If set and clear occur in the same cycle, set wins. Reset clears the flag.
- Undefined: wr_overflow is constant 0 and wr_ovf_clr is ignored. The ports remain present.

Test Plan:
(pADDR_WIDTH=4, pAFULL_THRESH=12, rd_ptr held 0 unless stated)
1. Reset: hold wr_rst_n=0 for 2 edges with wr_push=1 -> wr_addr=0, wr_ptr=5'b00000, wr_full=0, wr_level=0, wr_almost_full=0, wr_overflow=0.
2. Fill: 16 consecutive pushes -> wr_almost_full=1 after the 12th edge (wr_level=12). After the 16th edge: wr_full=1, wr_level=16, wr_ptr=5'b11000, wr_addr=0.
3. Overflow: from full, push once -> wr_en=0, wr_ptr stays 5'b11000. With WR_OVF_FLAG_EN defined, wr_overflow=1 and stays 1. After wr_ovf_clr pulse -> 0. Without the macro it stays 0.
4. Drain visibility: from full, set rd_ptr=Gray(4)=5'b00110 -> next edge: wr_full=0, wr_level=12, wr_almost_full=1. Then set rd_ptr=Gray(5)=5'b00111 -> wr_level=11, wr_almost_full=0.
5. Wrap: 40 pushes with rd_ptr tracking wr_ptr two cycles late -> wr_full never set. wr_ptr walks the Gray sequence 0..31 then 0 with one bit change per step, and wr_addr wraps 15 -> 0.
6. Mid-operation reset: after 7 pushes, pull wr_rst_n low for one edge with wr_push=1 -> all outputs 0 at that edge. Then 1 push -> wr_addr=1, wr_level=1.

Source files
------------

// File: rtl/wr_ctrl_lvl.sv
// Write-side pointer/flag control for the dual-clock FIFO: Gray write pointer,
// registered full / almost-full / level, optional sticky overflow (WR_OVF_FLAG_EN).
module wr_ctrl_lvl #(
    parameter int pADDR_WIDTH   = 4,
    parameter int pAFULL_THRESH = 12
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst_n,
    input  logic                   wr_push,
    input  logic                   wr_ovf_clr,
    input  logic [pADDR_WIDTH:0]   rd_ptr,
    output logic                   wr_en,
    output logic [pADDR_WIDTH-1:0] wr_addr,
    output logic [pADDR_WIDTH:0]   wr_ptr,
    output logic                   wr_full,
    output logic                   wr_almost_full,
    output logic [pADDR_WIDTH:0]   wr_level,
    output logic                   wr_overflow
);

    localparam int PW = pADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL = PW'(pAFULL_THRESH);

    logic [PW-1:0] wr_bin;
    logic [PW-1:0] wr_bin_nxt;
    logic [PW-1:0] wr_gray_nxt;
    logic [PW-1:0] rd_bin_s;
    logic [PW-1:0] rd_full_gray;
    logic [PW-1:0] lvl_nxt;
    logic          full_val;

    assign wr_en       = wr_push && !wr_full;
    assign wr_bin_nxt  = wr_bin + PW'(wr_en);
    assign wr_gray_nxt = wr_bin_nxt ^ (wr_bin_nxt >> 1);
    assign wr_addr     = wr_bin[pADDR_WIDTH-1:0];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rd_bin_s = '0;
        for (int i = 0; i < PW; i++)
            rd_bin_s[i] = ^(rd_ptr >> i);
    end

    // A pointer exactly one lap ahead differs from the read pointer in its top two Gray bits.
    assign rd_full_gray = {~rd_ptr[PW-1:PW-2], rd_ptr[PW-3:0]};
    assign full_val     = (wr_gray_nxt == rd_full_gray);
    assign lvl_nxt      = wr_bin_nxt - rd_bin_s;

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            wr_bin         <= '0;
            wr_ptr         <= '0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_level       <= '0;
        end else begin
            wr_bin         <= wr_bin_nxt;
            wr_ptr         <= wr_gray_nxt;
            wr_full        <= full_val;
            wr_almost_full <= (lvl_nxt >= AFULL);
            wr_level       <= lvl_nxt;
        end
    end

`ifdef WR_OVF_FLAG_EN
    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n)
            wr_overflow <= 1'b0;
        else if (wr_push && wr_full)
            wr_overflow <= 1'b1;
        else if (wr_ovf_clr)
            wr_overflow <= 1'b0;
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = wr_ovf_clr;
    assign wr_overflow    = 1'b0;
`endif

endmodule
